vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 93 +++++++++
 tb/tb_vga_sync_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-rate divider, h/v counters, sync and video_on.
// Optional frame-wrap strobe f_tick is enabled by defining VGA_SYNC_FRAME_TICK_EN.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
`ifdef VGA_SYNC_FRAME_TICK_EN
    output logic       f_tick,
`endif
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [DIV_W-1:0] r_div_count;
    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;
    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_p_tick;
    logic             w_h_end;
    logic             w_v_end;

    assign w_p_tick = (r_div_count == DIV_W'(CLK_DIV - 1));
    assign w_h_end  = (r_h_count == CNT_W'(H_TOTAL - 1));
    assign w_v_end  = (r_v_count == CNT_W'(V_TOTAL - 1));

    // Next-state counts; sync is decoded from these so it lines up with pixel_x/pixel_y.
    always_comb begin
        w_h_next = r_h_count;
        w_v_next = r_v_count;
        if (w_p_tick) begin
            if (w_h_end) begin
                w_h_next = '0;
                w_v_next = w_v_end ? '0 : r_v_count + CNT_W'(1);
            end else begin
                w_h_next = r_h_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_count <= '0;
            r_h_count   <= '0;
            r_v_count   <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
        end else begin
            r_div_count <= w_p_tick ? '0 : r_div_count + DIV_W'(1);
            r_h_count   <= w_h_next;
            r_v_count   <= w_v_next;
            r_hsync     <= !((w_h_next >= CNT_W'(HS_START)) && (w_h_next <= CNT_W'(HS_END)));
            r_vsync     <= !((w_v_next >= CNT_W'(VS_START)) && (w_v_next <= CNT_W'(VS_END)));
        end
    end

    assign p_tick   = w_p_tick;
    assign pixel_x  = r_h_count;
    assign pixel_y  = r_v_count;
    assign video_on = (r_h_count < CNT_W'(H_DISPLAY)) && (r_v_count < CNT_W'(V_DISPLAY));
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;

`ifdef VGA_SYNC_FRAME_TICK_EN
    // High in the cycle whose closing edge wraps the frame back to (0,0).
    assign f_tick = w_p_tick && w_h_end && w_v_end;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance plus a shrunken instance
// so full-frame wrap and vsync behaviour can be covered in a few hundred clocks.
module tb_vga_sync_gen;

    logic       clk;
    logic       reset;
    logic       a_pt, a_von, a_hs, a_vs, a_ft;
    logic [9:0] a_px, a_py;
    logic       b_pt, b_von, b_hs, b_vs, b_ft;
    logic [9:0] b_px, b_py;

    int n_tests;
    int n_fail;

    vga_sync_gen u_dut_a (
        .clk      (clk),
        .reset    (reset),
`ifdef VGA_SYNC_FRAME_TICK_EN
        .f_tick   (a_ft),
`endif
        .p_tick   (a_pt),
        .pixel_x  (a_px),
        .pixel_y  (a_py),
        .video_on (a_von),
        .hsync    (a_hs),
        .vsync    (a_vs)
    );

    // Small timing: H 8+2+3+2=15, V 4+1+2+1=8, CLK_DIV 2 -> 240 clks per frame.
    vga_sync_gen #(
        .CLK_DIV  (2),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
`ifdef VGA_SYNC_FRAME_TICK_EN
        .f_tick   (b_ft),
`endif
        .p_tick   (b_pt),
        .pixel_x  (b_px),
        .pixel_y  (b_py),
        .video_on (b_von),
        .hsync    (b_hs),
        .vsync    (b_vs)
    );

`ifndef VGA_SYNC_FRAME_TICK_EN
    assign a_ft = 1'b0;
    assign b_ft = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input int n);
        @(negedge clk) reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_pt;
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (a_px !== 10'd0 || a_py !== 10'd0) begin n_fail++; $display("FAIL reset_xy: got (%0d,%0d) exp (0,0)", a_px, a_py); end
        n_tests++; if (a_hs !== 1'b1 || a_vs !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b exp 1 1", a_hs, a_vs); end
        n_tests++; if (a_von !== 1'b1) begin n_fail++; $display("FAIL reset_video_on: got %b exp 1", a_von); end
        n_tests++; if (a_pt !== 1'b0) begin n_fail++; $display("FAIL reset_p_tick: got %b exp 0", a_pt); end
        n_tests++; if (b_px !== 10'd0 || b_py !== 10'd0 || b_hs !== 1'b1 || b_vs !== 1'b1) begin
            n_fail++; $display("FAIL reset_small: got (%0d,%0d) hs=%b vs=%b exp (0,0) 1 1", b_px, b_py, b_hs, b_vs); end
        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            exp_pt = ((k % 4) == 3);
            n_tests++; if (a_pt !== exp_pt) begin n_fail++; $display("FAIL p_tick_period k=%0d: got %b exp %b", k, a_pt, exp_pt); end
            if (k == 3) begin
                n_tests++; if (a_px !== 10'd0) begin n_fail++; $display("FAIL first_tick_x: got %0d exp 0", a_px); end
            end
            if (k == 4) begin
                n_tests++; if (a_px !== 10'd1) begin n_fail++; $display("FAIL first_step_x: got %0d exp 1", a_px); end
            end
        end
    endtask

    task automatic test_line_timing();
        int hs_low, vid_off, ticks, ft_cnt, hs_min, hs_max;
        hs_low = 0; vid_off = 0; ticks = 0; ft_cnt = 0; hs_min = 1023; hs_max = -1;
        apply_reset(2);
        for (int k = 1; k <= 3200; k++) begin
            @(posedge clk); #1;
            if (a_hs === 1'b0) begin
                hs_low++;
                if (int'(a_px) < hs_min) hs_min = int'(a_px);
                if (int'(a_px) > hs_max) hs_max = int'(a_px);
            end
            if (a_von === 1'b0) vid_off++;
            if (a_pt === 1'b1) ticks++;
            if (a_ft === 1'b1) ft_cnt++;
            if (k == 3196 || k == 3198) begin
                n_tests++; if (a_px !== 10'd799 || a_py !== 10'd0) begin n_fail++; $display("FAIL line_hold k=%0d: got (%0d,%0d) exp (799,0)", k, a_px, a_py); end
            end
            if (k == 3199) begin
                n_tests++; if (a_pt !== 1'b1 || a_px !== 10'd799) begin n_fail++; $display("FAIL line_end: got x=%0d pt=%b exp 799 1", a_px, a_pt); end
            end
            if (k == 3200) begin
                n_tests++; if (a_px !== 10'd0 || a_py !== 10'd1) begin n_fail++; $display("FAIL line_wrap: got (%0d,%0d) exp (0,1)", a_px, a_py); end
            end
        end
        n_tests++; if (hs_low != 384) begin n_fail++; $display("FAIL hsync_width: got %0d clks exp 384", hs_low); end
        n_tests++; if (hs_min != 656 || hs_max != 751) begin n_fail++; $display("FAIL hsync_span: got %0d..%0d exp 656..751", hs_min, hs_max); end
        n_tests++; if (vid_off != 640) begin n_fail++; $display("FAIL h_blank: got %0d clks exp 640", vid_off); end
        n_tests++; if (ticks != 800) begin n_fail++; $display("FAIL line_ticks: got %0d exp 800", ticks); end
        n_tests++; if (ft_cnt != 0) begin n_fail++; $display("FAIL line_f_tick: got %0d exp 0", ft_cnt); end
    endtask

    task automatic test_frame_wrap();
        int vs_low, hs_low, vid_off, ft_cnt, vs_min, vs_max;
        vs_low = 0; hs_low = 0; vid_off = 0; ft_cnt = 0; vs_min = 1023; vs_max = -1;
        apply_reset(2);
        for (int k = 1; k <= 240; k++) begin
            @(posedge clk); #1;
            if (b_vs === 1'b0) begin
                vs_low++;
                if (int'(b_py) < vs_min) vs_min = int'(b_py);
                if (int'(b_py) > vs_max) vs_max = int'(b_py);
            end
            if (b_hs === 1'b0) hs_low++;
            if (b_von === 1'b0) vid_off++;
            if (b_ft === 1'b1) begin
                ft_cnt++;
                n_tests++; if (k != 239) begin n_fail++; $display("FAIL f_tick_pos: got k=%0d exp 239", k); end
            end
            if (k == 239) begin
                n_tests++; if (b_px !== 10'd14 || b_py !== 10'd7 || b_pt !== 1'b1) begin
                    n_fail++; $display("FAIL frame_end: got (%0d,%0d) pt=%b exp (14,7) 1", b_px, b_py, b_pt); end
            end
            if (k == 240) begin
                n_tests++; if (b_px !== 10'd0 || b_py !== 10'd0 || b_vs !== 1'b1) begin
                    n_fail++; $display("FAIL frame_wrap: got (%0d,%0d) vs=%b exp (0,0) 1", b_px, b_py, b_vs); end
            end
        end
        n_tests++; if (vs_low != 60) begin n_fail++; $display("FAIL vsync_width: got %0d clks exp 60", vs_low); end
        n_tests++; if (vs_min != 5 || vs_max != 6) begin n_fail++; $display("FAIL vsync_span: got %0d..%0d exp 5..6", vs_min, vs_max); end
        n_tests++; if (hs_low != 48) begin n_fail++; $display("FAIL frame_hsync: got %0d clks exp 48", hs_low); end
        n_tests++; if (vid_off != 176) begin n_fail++; $display("FAIL frame_blank: got %0d clks exp 176", vid_off); end
`ifdef VGA_SYNC_FRAME_TICK_EN
        n_tests++; if (ft_cnt != 1) begin n_fail++; $display("FAIL f_tick_count: got %0d exp 1", ft_cnt); end
`endif
    endtask

    task automatic test_mid_frame_reset();
        logic exp_a, exp_b;
        apply_reset(1);
        repeat (170) @(posedge clk);
        #1;
        n_tests++; if (b_px !== 10'd10 || b_py !== 10'd5 || b_hs !== 1'b0 || b_vs !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre: got (%0d,%0d) hs=%b vs=%b exp (10,5) 0 0", b_px, b_py, b_hs, b_vs); end
        n_tests++; if (a_px !== 10'd42 || a_py !== 10'd0) begin n_fail++; $display("FAIL mid_pre_a: got (%0d,%0d) exp (42,0)", a_px, a_py); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (b_px !== 10'd0 || b_py !== 10'd0 || b_hs !== 1'b1 || b_vs !== 1'b1 || b_pt !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got (%0d,%0d) hs=%b vs=%b pt=%b exp (0,0) 1 1 0", b_px, b_py, b_hs, b_vs, b_pt); end
        n_tests++; if (a_px !== 10'd0 || a_py !== 10'd0 || a_pt !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_a: got (%0d,%0d) pt=%b exp (0,0) 0", a_px, a_py, a_pt); end
        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            exp_a = ((k % 4) == 3);
            exp_b = ((k % 2) == 1);
            n_tests++; if (a_pt !== exp_a || b_pt !== exp_b) begin
                n_fail++; $display("FAIL mid_divider k=%0d: got a=%b b=%b exp a=%b b=%b", k, a_pt, b_pt, exp_a, exp_b); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        test_reset();
        test_line_timing();
        test_frame_wrap();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
